// File: rtl/thr_wait_ctl.sv
// Per-thread wait-mask and scheduling state controller for a 4-thread core.
// Tracks I-miss, long-latency and store-buffer waits and arbitrates the single RUN slot.

package thr_wait_pkg;
  localparam int NUM_THR = 4;

  // Shared IFU thread-FSM encodings; any other value is treated as illegal.
  typedef enum logic [4:0] {
    THRFSM_WAIT     = 5'b00001,
    THRFSM_RUN      = 5'b00101,
    THRFSM_SPEC_RUN = 5'b00111,
    THRFSM_SPEC_RDY = 5'b10011,
    THRFSM_RDY      = 5'b11001
  } thr_state_e;
endpackage

module thr_wait_ctl
  import thr_wait_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] imiss_set,
  input  logic [3:0] imiss_clr,
  input  logic [3:0] other_set,
  input  logic [3:0] completion,
  input  logic [3:0] spec_wake,
  input  logic [3:0] kill_spec,
  input  logic [3:0] stb_set,
  input  logic [3:0] stb_clr,
  input  logic [3:0] sel_thr,
  input  logic [3:0] switch_out,
  output logic [3:0] wm_imiss,
  output logic [3:0] wm_other,
  output logic [3:0] wm_stbwait,
  output logic [4:0] thr_state0,
  output logic [4:0] thr_state1,
  output logic [4:0] thr_state2,
  output logic [4:0] thr_state3,
  output logic [3:0] rdy_vec,
  output logic [3:0] run_vec
);

  thr_state_e state_q [NUM_THR];
  thr_state_e state_d [NUM_THR];

  logic [3:0] wm_imiss_q, wm_imiss_d;
  logic [3:0] wm_other_q, wm_other_d;
  logic [3:0] wm_stbwait_q, wm_stbwait_d;

  logic [3:0] in_rdy;
  logic [3:0] in_run;
  logic [3:0] in_spec;
  logic [3:0] kill_i;
  logic [3:0] wait_nxt;
  logic [3:0] woke_spec;
  logic [3:0] holds_cpu;
  logic [3:0] grant;
  logic       sel_onehot;

  // Decode the current state of each thread into its scheduling classes.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    in_rdy  = '0;
    in_run  = '0;
    in_spec = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      case (state_q[i])
        THRFSM_RDY:      in_rdy[i] = 1'b1;
        THRFSM_SPEC_RDY: begin
          in_rdy[i]  = 1'b1;
          in_spec[i] = 1'b1;
        end
        THRFSM_RUN:      in_run[i] = 1'b1;
        THRFSM_SPEC_RUN: begin
          in_run[i]  = 1'b1;
          in_spec[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A kill only undoes a speculative wake that actually took effect.
  assign kill_i = kill_spec & in_spec;

  assign wm_imiss_d   = imiss_set | (wm_imiss_q & ~imiss_clr);
  assign wm_stbwait_d = stb_set | (wm_stbwait_q & ~stb_clr);
  assign wm_other_d   = other_set | kill_i | (wm_other_q & ~(completion | spec_wake));

  assign wait_nxt  = wm_imiss_d | wm_other_d | wm_stbwait_d;
  assign woke_spec = wm_other_q & spec_wake & ~completion;

  // The RUN slot is free next cycle unless its current owner neither switches out nor blocks.
  assign holds_cpu  = in_run & ~switch_out & ~wait_nxt;
  assign sel_onehot = (sel_thr != 4'd0) && ((sel_thr & (sel_thr - 4'd1)) == 4'd0);
  assign grant      = (sel_onehot && !(|holds_cpu)) ? (sel_thr & in_rdy) : 4'd0;

  always_comb begin
    for (int i = 0; i < NUM_THR; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        THRFSM_WAIT:
          state_d[i] = woke_spec[i] ? THRFSM_SPEC_RDY : THRFSM_RDY;
        THRFSM_RDY:
          state_d[i] = grant[i] ? THRFSM_RUN : THRFSM_RDY;
        THRFSM_SPEC_RDY: begin
          if (grant[i])
            state_d[i] = completion[i] ? THRFSM_RUN : THRFSM_SPEC_RUN;
          else if (completion[i])
            state_d[i] = THRFSM_RDY;
          else
            state_d[i] = THRFSM_SPEC_RDY;
        end
        THRFSM_RUN:
          state_d[i] = switch_out[i] ? THRFSM_RDY : THRFSM_RUN;
        THRFSM_SPEC_RUN: begin
          if (switch_out[i])
            state_d[i] = completion[i] ? THRFSM_RDY : THRFSM_SPEC_RDY;
          else if (completion[i])
            state_d[i] = THRFSM_RUN;
          else
            state_d[i] = THRFSM_SPEC_RUN;
        end
        default:
          state_d[i] = THRFSM_RDY;
      endcase
      // Any pending wait overrides every other transition, including illegal-state recovery.
      if (wait_nxt[i]) state_d[i] = THRFSM_WAIT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wm_imiss_q   <= '0;
      wm_other_q   <= '0;
      wm_stbwait_q <= '0;
      for (int i = 0; i < NUM_THR; i++) state_q[i] <= THRFSM_RDY;
    end else begin
      wm_imiss_q   <= wm_imiss_d;
      wm_other_q   <= wm_other_d;
      wm_stbwait_q <= wm_stbwait_d;
      for (int i = 0; i < NUM_THR; i++) state_q[i] <= state_d[i];
    end
  end

  assign wm_imiss   = wm_imiss_q;
  assign wm_other   = wm_other_q;
  assign wm_stbwait = wm_stbwait_q;
  assign thr_state0 = state_q[0];
  assign thr_state1 = state_q[1];
  assign thr_state2 = state_q[2];
  assign thr_state3 = state_q[3];
  assign rdy_vec    = in_rdy;
  assign run_vec    = in_run;

endmodule
